// File: rtl/lsb_watermark_embed_pkg.sv
// Shared types and constants for the LSB watermark embedder: FSM states,
// channel-mask bit positions and the scrambler LFSR definition.
package lsb_wm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMBED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  localparam int         LFSR_W    = 8;
  // x^8+x^6+x^5+x^4+1 on a right-shifting register: feedback from bits 0,2,3,4
  localparam logic [7:0] LFSR_TAPS = 8'b0001_1101;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

  function automatic logic [7:0] embed_ch(input logic [7:0] d, input logic en,
                                          input logic b);
    logic [7:0] r;
    r = d;
    if (en) begin
      r[0] = b;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsb_watermark_embed_lfsr.sv
// Watermark scrambler LFSR: loads SEED, steps twice per accepted pixel pair.
// Only built when WM_SCRAMBLE_EN is defined.
`ifdef WM_SCRAMBLE_EN
module wm_lfsr8
  import lsb_wm_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic step2_i,
  output logic bit0_o,
  output logic bit1_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_1_s;

  assign lfsr_1_s = lfsr_step(lfsr_q);
  assign bit0_o   = lfsr_q[0];
  assign bit1_o   = lfsr_1_s[0];

  // LFSR state: seeded on reset and frame start, two steps per pair
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else if (load_i) begin
      lfsr_q <= SEED;
    end else if (step2_i) begin
      lfsr_q <= lfsr_step(lfsr_1_s);
    end
  end

endmodule
`endif

// File: rtl/lsb_watermark_embed.sv
// Embeds one watermark bit per pixel into the LSB of the masked colour channels
// of a two-pixel-per-cycle stream. Optional scrambling via WM_SCRAMBLE_EN.
module lsb_watermark_embed
  import lsb_wm_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter int         HEIGHT  = 8,
  parameter logic [2:0] CH_MASK = 3'b001,
  parameter logic [7:0] SEED    = 8'hA5,
  localparam int NPIX   = WIDTH * HEIGHT,
  localparam int PAIRS  = NPIX / 2,
  localparam int NBYTES = NPIX / 8,
  localparam int ADDR_W = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int P_W    = $clog2(PAIRS)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              wm_wr_en,
  input  logic [ADDR_W-1:0] wm_wr_addr,
  input  logic [7:0]        wm_wr_data,
  input  logic              in_valid,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              hsync,
  output logic [7:0]        DATA_WRITE_R0,
  output logic [7:0]        DATA_WRITE_G0,
  output logic [7:0]        DATA_WRITE_B0,
  output logic [7:0]        DATA_WRITE_R1,
  output logic [7:0]        DATA_WRITE_G1,
  output logic [7:0]        DATA_WRITE_B1,
  output logic              busy,
  output logic              frame_done
);

  state_e          state_q, state_d;
  logic [P_W-1:0]  p_q, p_d;
  logic [NPIX-1:0] wm_q;
  logic            accept_s, enter_s, last_s;
  logic [P_W:0]    idx0_s, idx1_s;
  logic            wb0_s, wb1_s;
  logic            hsync_q, frame_done_q;
  logic [7:0]      r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;

  assign idx0_s = {p_q, 1'b0};
  assign idx1_s = {p_q, 1'b1};

`ifdef WM_SCRAMBLE_EN
  logic lb0_s, lb1_s;

  wm_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .load_i  (enter_s),
    .step2_i (accept_s),
    .bit0_o  (lb0_s),
    .bit1_o  (lb1_s)
  );

  assign wb0_s = wm_q[idx0_s] ^ lb0_s;
  assign wb1_s = wm_q[idx1_s] ^ lb1_s;
`else
  assign wb0_s = wm_q[idx0_s];
  assign wb1_s = wm_q[idx1_s];
`endif

  // Next-state logic; start is only honoured outside EMBED
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    accept_s = 1'b0;
    enter_s  = 1'b0;
    last_s   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = EMBED;
          p_d     = '0;
          enter_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      EMBED: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (p_q == P_W'(PAIRS - 1)) begin
            last_s  = 1'b1;
            state_d = DONE;
          end else begin
            p_d = p_q + {{(P_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = EMBED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= IDLE;
      p_q          <= '0;
      hsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      hsync_q      <= accept_s;
      frame_done_q <= last_s;
    end
  end

  // Watermark memory is frozen for the whole frame
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wm_q <= '0;
    end else if (wm_wr_en && (state_q != EMBED)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wm_wr_addr == ADDR_W'(b)) begin
          wm_q[b*8 +: 8] <= wm_wr_data;
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r0_q <= 8'h00; g0_q <= 8'h00; b0_q <= 8'h00;
      r1_q <= 8'h00; g1_q <= 8'h00; b1_q <= 8'h00;
    end else if (accept_s) begin
      r0_q <= embed_ch(DATA_R0, CH_MASK[CH_R], wb0_s);
      g0_q <= embed_ch(DATA_G0, CH_MASK[CH_G], wb0_s);
      b0_q <= embed_ch(DATA_B0, CH_MASK[CH_B], wb0_s);
      r1_q <= embed_ch(DATA_R1, CH_MASK[CH_R], wb1_s);
      g1_q <= embed_ch(DATA_G1, CH_MASK[CH_G], wb1_s);
      b1_q <= embed_ch(DATA_B1, CH_MASK[CH_B], wb1_s);
    end
  end

  assign hsync         = hsync_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q == EMBED);
  assign DATA_WRITE_R0 = r0_q;
  assign DATA_WRITE_G0 = g0_q;
  assign DATA_WRITE_B0 = b0_q;
  assign DATA_WRITE_R1 = r1_q;
  assign DATA_WRITE_G1 = g1_q;
  assign DATA_WRITE_B1 = b1_q;

endmodule

// File: tb/tb_lsb_watermark_embed.sv
// Self-checking bench: two embedders (channel masks 001 and 111) share one
// stimulus stream and are checked every cycle against a frame-level model.
module tb_lsb_watermark_embed;
  import lsb_wm_pkg::*;

  localparam int PAIRS = 32;
`ifdef WM_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic       HCLK = 1'b0;
  logic       HRESET, start, wm_wr_en, in_valid;
  logic [2:0] wm_wr_addr;
  logic [7:0] wm_wr_data;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;

  logic       hs1, fd1, bz1, hs7, fd7, bz7;
  logic [7:0] o1 [6];
  logic [7:0] o7 [6];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int fd_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 HCLK = ~HCLK;

  lsb_watermark_embed #(.CH_MASK(3'b001)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .wm_wr_en(wm_wr_en),
    .wm_wr_addr(wm_wr_addr), .wm_wr_data(wm_wr_data), .in_valid(in_valid),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .hsync(hs1),
    .DATA_WRITE_R0(o1[0]), .DATA_WRITE_G0(o1[1]), .DATA_WRITE_B0(o1[2]),
    .DATA_WRITE_R1(o1[3]), .DATA_WRITE_G1(o1[4]), .DATA_WRITE_B1(o1[5]),
    .busy(bz1), .frame_done(fd1));

  lsb_watermark_embed #(.CH_MASK(3'b111)) dut7 (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .wm_wr_en(wm_wr_en),
    .wm_wr_addr(wm_wr_addr), .wm_wr_data(wm_wr_data), .in_valid(in_valid),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .hsync(hs7),
    .DATA_WRITE_R0(o7[0]), .DATA_WRITE_G0(o7[1]), .DATA_WRITE_B0(o7[2]),
    .DATA_WRITE_R1(o7[3]), .DATA_WRITE_G1(o7[4]), .DATA_WRITE_B1(o7[5]),
    .busy(bz7), .frame_done(fd7));

  // ---------------- reference model ----------------
  function automatic logic [7:0] lf_next(input logic [7:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[4];
    return {fb, s[7:1]};
  endfunction

  function automatic logic lf_bit1(input logic [7:0] s);
    logic [7:0] n;
    n = lf_next(s);
    return n[0];
  endfunction

  // Clear the LSB arithmetically and add the watermark bit when the channel is selected.
  function automatic logic [7:0] emb(input logic [7:0] d, input logic en, input logic b);
    logic [7:0] base;
    base = (d / 8'd2) * 8'd2;
    return en ? (base + {7'd0, b}) : d;
  endfunction

  logic        m_wm [64];
  logic        m_active;
  int          m_k;
  logic [7:0]  m_l;
  logic        e_hs, e_fd;
  logic [7:0]  e1 [6];
  logic [7:0]  e7 [6];
  logic        m_b0, m_b1;

  assign m_b0 = m_wm[2*m_k]   ^ (SCR & m_l[0]);
  assign m_b1 = m_wm[2*m_k+1] ^ (SCR & lf_bit1(m_l));

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_l      <= 8'hA5;
      e_hs     <= 1'b0;
      e_fd     <= 1'b0;
      for (int i = 0; i < 64; i++) m_wm[i] <= 1'b0;
      for (int c = 0; c < 6; c++) begin
        e1[c] <= 8'h00;
        e7[c] <= 8'h00;
      end
    end else begin
      e_hs <= 1'b0;
      e_fd <= 1'b0;
      if (m_active) begin
        if (in_valid) begin
          e1[0] <= emb(DATA_R0, 1'b0, m_b0); e7[0] <= emb(DATA_R0, 1'b1, m_b0);
          e1[1] <= emb(DATA_G0, 1'b0, m_b0); e7[1] <= emb(DATA_G0, 1'b1, m_b0);
          e1[2] <= emb(DATA_B0, 1'b1, m_b0); e7[2] <= emb(DATA_B0, 1'b1, m_b0);
          e1[3] <= emb(DATA_R1, 1'b0, m_b1); e7[3] <= emb(DATA_R1, 1'b1, m_b1);
          e1[4] <= emb(DATA_G1, 1'b0, m_b1); e7[4] <= emb(DATA_G1, 1'b1, m_b1);
          e1[5] <= emb(DATA_B1, 1'b1, m_b1); e7[5] <= emb(DATA_B1, 1'b1, m_b1);
          e_hs  <= 1'b1;
          e_fd  <= (m_k == PAIRS - 1);
          m_l   <= lf_next(lf_next(m_l));
          if (m_k == PAIRS - 1) m_active <= 1'b0;
          m_k   <= m_k + 1;
        end
      end else begin
        if (wm_wr_en) begin
          for (int i = 0; i < 8; i++) m_wm[int'(wm_wr_addr)*8 + i] <= wm_wr_data[i];
        end
        if (start) begin
          m_active <= 1'b1;
          m_k      <= 0;
          m_l      <= 8'hA5;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (cmp_en) begin
      chk("hsync_m1", {7'd0, hs1}, {7'd0, e_hs});
      chk("fdone_m1", {7'd0, fd1}, {7'd0, e_fd});
      chk("busy_m1",  {7'd0, bz1}, {7'd0, m_active});
      chk("hsync_m7", {7'd0, hs7}, {7'd0, e_hs});
      chk("fdone_m7", {7'd0, fd7}, {7'd0, e_fd});
      for (int c = 0; c < 6; c++) begin
        chk($sformatf("data_m1[%0d]", c), o1[c], e1[c]);
        chk($sformatf("data_m7[%0d]", c), o7[c], e7[c]);
      end
      if (hs7) hs_cnt++;
      if (fd7) fd_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wm_wr_en = 1'b1; wm_wr_addr = 3'(a); wm_wr_data = d;
    cyc();
    wm_wr_en = 1'b0;
  endtask

  task automatic pair(input logic v, input logic [7:0] r0, g0, b0, r1, g1, b1);
    in_valid = v;
    DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
    DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
    cyc();
  endtask

  task automatic pairu(input logic v, input logic [7:0] d);
    pair(v, d, d, d, d, d, d);
  endtask

  task automatic pairr();
    pair(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; wm_wr_en = 1'b0; wm_wr_addr = 3'd0;
    wm_wr_data = 8'h00; in_valid = 1'b0;
    DATA_R0 = 8'h00; DATA_G0 = 8'h00; DATA_B0 = 8'h00;
    DATA_R1 = 8'h00; DATA_G1 = 8'h00; DATA_B1 = 8'h00;
    cyc();
    cmp_en = 1'b1;
    cyc(); cyc();
    HRESET = 1'b0;

    // Idle: valid without start does nothing
    for (int i = 0; i < 4; i++) pairu(1'b1, 8'hFE);
    chk("idle_hsync", {7'd0, hs1}, 8'h00);
    chk("idle_B0", o1[2], 8'h00);
    chk("idle_busy", {7'd0, bz1}, 8'h00);
    pairu(1'b0, 8'h00);

    // Basic frame, watermark 0x55
    for (int b = 0; b < 8; b++) wr(b, 8'h55);
    pulse_start();
    for (int k = 0; k < PAIRS; k++) begin
      pairu(1'b1, 8'hFE);
      if (k == 0) begin
        chk("p0_hsync", {7'd0, hs1}, 8'h01);
        chk("p0_B0", o1[2], SCR ? 8'hFE : 8'hFF);
        chk("p0_B1", o1[5], 8'hFE);
        chk("p0_R0", o1[0], 8'hFE);
        chk("p0_G1", o1[4], 8'hFE);
      end
      if (k == PAIRS - 1) begin
        chk("last_hsync", {7'd0, hs1}, 8'h01);
        chk("last_fdone", {7'd0, fd1}, 8'h01);
      end
    end
    pairu(1'b0, 8'h00);
    chk("fdone_pulse", {7'd0, fd1}, 8'h00);
    chk("done_busy", {7'd0, bz1}, 8'h00);

    // Zero watermark, gapped valid, start coincident with valid
    for (int b = 0; b < 8; b++) wr(b, 8'h00);
    hs_cnt = 0; fd_cnt = 0;
    in_valid = 1'b1; DATA_R0 = 8'h01; DATA_G0 = 8'h01; DATA_B0 = 8'h01;
    DATA_R1 = 8'h01; DATA_G1 = 8'h01; DATA_B1 = 8'h01;
    pulse_start();
    chk("start_valid_ignored", {7'd0, hs1}, 8'h00);
    for (int k = 0; k < PAIRS; k++) begin
      pairu(1'b1, 8'h01);
      if (k == 0) begin
        chk("gap_m7_R0", o7[0], SCR ? 8'h01 : 8'h00);
        chk("gap_m7_G1", o7[4], 8'h00);
        chk("gap_m1_B0", o1[2], SCR ? 8'h01 : 8'h00);
        chk("gap_m1_R0", o1[0], 8'h01);
      end
      pairu(1'b0, 8'h01);
    end
    cyc();
    chk("gap_hsync_count", 8'(hs_cnt), 8'd32);
    chk("gap_fdone_count", 8'(fd_cnt), 8'd1);

    // Write protection during EMBED, start ignored mid-frame
    wr(0, 8'h00);
    for (int b = 1; b < 8; b++) wr(b, 8'hFF);
    pulse_start();
    wr(0, 8'hFF);
    pairu(1'b1, 8'hFE);
    chk("wprot_B0", o1[2], SCR ? 8'hFF : 8'hFE);
    chk("wprot_m7_R0", o7[0], SCR ? 8'hFF : 8'hFE);
    in_valid = 1'b0;
    pulse_start();
    for (int k = 1; k <= 10; k++) pairr();

    // Asynchronous reset mid-frame
    #2;
    HRESET = 1'b1;
    #1;
    chk("rst_hsync", {7'd0, hs1}, 8'h00);
    chk("rst_busy", {7'd0, bz1}, 8'h00);
    chk("rst_B0", o1[2], 8'h00);
    chk("rst_m7_R1", o7[3], 8'h00);
    cyc(); cyc();
    HRESET = 1'b0;
    in_valid = 1'b0;
    cyc();
    pulse_start();
    for (int k = 0; k < PAIRS; k++) begin
      if (k == 4) begin
        pairu(1'b1, 8'hFE);
        chk("cleared_mem_m7_R0", o7[0], 8'hFE ^ {7'd0, SCR & 1'b0});
      end else begin
        pairr();
      end
    end
    pairu(1'b0, 8'h00);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
